// File: rtl/network_pkg.sv
// Shared types and default sizing for the spiking-network output stage.
// The decoder derives its counter width locally from these defaults.
package network_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNT   = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } dec_state_t;

    localparam int OUTPUT_SIZE_DEF  = 4;
    localparam int SPIKE_WINDOW_DEF = 16;

endpackage

// File: rtl/output_spike_decoder.sv
// Counts output-layer spikes over a fixed window and reports the winning neuron
// (lowest index on ties) through a valid/ready result handshake.
//
// state     | meaning
// S_IDLE    | waiting for start; result registers hold the last decode
// S_COUNT   | accumulating spikes on each step_valid until the window fills
// S_COMPARE | scanning neuron counters one per cycle, then latching the result
// S_DONE    | result_valid high until result_ready
module output_spike_decoder
    import network_pkg::*;
#(
    parameter int OUTPUT_SIZE  = OUTPUT_SIZE_DEF,
    parameter int SPIKE_WINDOW = SPIKE_WINDOW_DEF,
    parameter int CNT_WIDTH    = $clog2(SPIKE_WINDOW + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   step_valid,
    input  logic [OUTPUT_SIZE-1:0] spike_in,
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [((OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1)-1:0] class_id,
    output logic [CNT_WIDTH-1:0]   class_count,
    output logic                   tie,
    output logic                   no_spike
);

    localparam int ID_W   = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam int SCAN_W = $clog2(OUTPUT_SIZE + 1);

    dec_state_t r_state, w_state_nxt;

    logic [CNT_WIDTH-1:0] w_cnt [OUTPUT_SIZE];
    logic [CNT_WIDTH-1:0] w_cnt_sel;
    logic [CNT_WIDTH-1:0] r_step;
    logic [SCAN_W-1:0]    r_scan_idx;
    logic [CNT_WIDTH-1:0] r_max;
    logic [ID_W-1:0]      r_max_idx;
    logic                 r_tie_run;
    logic [ID_W-1:0]      r_class_id;
    logic [CNT_WIDTH-1:0] r_class_count;
    logic                 r_tie;
    logic                 r_no_spike;

    logic w_start_acc;
    logic w_step_acc;
    logic w_last_step;
    logic w_scan_done;

    assign w_start_acc = start && !abort && (r_state == S_IDLE);
    assign w_step_acc  = step_valid && !abort && (r_state == S_COUNT);
    assign w_last_step = w_step_acc && (r_step == CNT_WIDTH'(SPIKE_WINDOW - 1));
    assign w_scan_done = (r_state == S_COMPARE) && (r_scan_idx == SCAN_W'(OUTPUT_SIZE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (start)        w_state_nxt = S_COUNT;
                S_COUNT:   if (w_last_step)  w_state_nxt = S_COMPARE;
                S_COMPARE: if (w_scan_done)  w_state_nxt = S_DONE;
                S_DONE:    if (result_ready) w_state_nxt = S_IDLE;
                default:                     w_state_nxt = S_IDLE;
            endcase
        end
    end

    // The step counter bounds every neuron counter at SPIKE_WINDOW.
    for (genvar g = 0; g < OUTPUT_SIZE; g++) begin : g_cnt
        logic [CNT_WIDTH-1:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                      r_cnt <= '0;
            else if (abort || w_start_acc)   r_cnt <= '0;
            else if (w_step_acc && spike_in[g]) r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
        assign w_cnt[g] = r_cnt;
    end

    always_comb begin
        w_cnt_sel = '0;
        for (int i = 0; i < OUTPUT_SIZE; i++) begin
            if (r_scan_idx == SCAN_W'(i)) w_cnt_sel = w_cnt[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step        <= '0;
            r_scan_idx    <= '0;
            r_max         <= '0;
            r_max_idx     <= '0;
            r_tie_run     <= 1'b0;
            r_class_id    <= '0;
            r_class_count <= '0;
            r_tie         <= 1'b0;
            r_no_spike    <= 1'b0;
        end else if (abort || w_start_acc) begin
            r_step        <= '0;
            r_scan_idx    <= '0;
            r_max         <= '0;
            r_max_idx     <= '0;
            r_tie_run     <= 1'b0;
            r_class_id    <= '0;
            r_class_count <= '0;
            r_tie         <= 1'b0;
            r_no_spike    <= 1'b0;
        end else if (r_state == S_COUNT) begin
            if (w_step_acc) r_step <= r_step + CNT_WIDTH'(1);
            if (w_last_step) r_scan_idx <= '0;
        end else if (r_state == S_COMPARE) begin
            if (!w_scan_done) begin
                r_scan_idx <= r_scan_idx + SCAN_W'(1);
                if (r_scan_idx == '0) begin
                    r_max     <= w_cnt_sel;
                    r_max_idx <= '0;
                    r_tie_run <= 1'b0;
                end else if (w_cnt_sel > r_max) begin
                    r_max     <= w_cnt_sel;
                    r_max_idx <= ID_W'(r_scan_idx);
                    r_tie_run <= 1'b0;
                end else if (w_cnt_sel == r_max) begin
                    r_tie_run <= 1'b1;
                end
            end else begin
                r_class_id    <= r_max_idx;
                r_class_count <= r_max;
                r_tie         <= r_tie_run && (r_max != '0);
                r_no_spike    <= (r_max == '0);
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign result_valid = (r_state == S_DONE);
    assign class_id     = r_class_id;
    assign class_count  = r_class_count;
    assign tie          = r_tie;
    assign no_spike     = r_no_spike;

endmodule

// File: tb/tb_output_spike_decoder.sv
// Directed bench for output_spike_decoder: a driver queues expected results per
// window and a monitor compares them when result_valid rises.
module tb_output_spike_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       step_valid;
    logic [3:0] spike_in;
    logic       busy;
    logic       result_valid;
    logic       result_ready;
    logic [1:0] class_id;
    logic [4:0] class_count;
    logic       tie;
    logic       no_spike;

    output_spike_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .step_valid   (step_valid),
        .spike_in     (spike_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .class_id     (class_id),
        .class_count  (class_count),
        .tie          (tie),
        .no_spike     (no_spike)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    id;
        int    cnt;
        int    tie;
        int    nos;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && result_valid && !mon_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_class_id"},    int'(class_id),    e.id);
                chk({e.name, "_class_count"}, int'(class_count), e.cnt);
                chk({e.name, "_tie"},         int'(tie),         e.tie);
                chk({e.name, "_no_spike"},    int'(no_spike),    e.nos);
            end
        end
        mon_prev = rst_n && result_valid;
    end

    task automatic push(input string name, input int id, input int cnt, input int t, input int n);
        exp_t e;
        e.name = name; e.id = id; e.cnt = cnt; e.tie = t; e.nos = n;
        sb.push_back(e);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed_steps(input int n, input logic [3:0] pat);
        for (int i = 0; i < n; i++) begin
            spike_in   = pat;
            step_valid = 1'b1;
            @(negedge clk);
        end
        step_valid = 1'b0;
        spike_in   = 4'b0000;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!result_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!result_valid) chk({name, "_valid_timeout"}, 0, 1);
    endtask

    task automatic handshake(input string name);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk({name, "_idle_after_ready"}, int'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_busy"},         int'(busy),         0);
        chk({name, "_result_valid"}, int'(result_valid), 0);
        chk({name, "_class_id"},     int'(class_id),     0);
        chk({name, "_class_count"},  int'(class_count),  0);
        chk({name, "_tie"},          int'(tie),          0);
        chk({name, "_no_spike"},     int'(no_spike),     0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] snap_id;
        logic [4:0] snap_cnt;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        step_valid = 1'b0; spike_in = 4'b0000; result_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Steps while idle must not reach the counters.
        feed_steps(3, 4'b1111);
        chk("idle_steps_busy", int'(busy), 0);

        // Single winner, plus result latency after the last sampled step.
        push("one_hot", 2, 16, 0, 0);
        do_start();
        chk("count_busy", int'(busy), 1);
        feed_steps(16, 4'b0100);
        wait_valid("one_hot", n);
        chk("one_hot_latency", n, 5);
        handshake("one_hot");

        push("silent", 0, 0, 0, 1);
        do_start();
        feed_steps(16, 4'b0000);
        wait_valid("silent", n);
        handshake("silent");

        // Neurons 1 and 3 reach 8, neurons 0 and 2 reach 3.
        push("tie", 1, 8, 1, 0);
        do_start();
        feed_steps(3, 4'b1111);
        feed_steps(5, 4'b1010);
        feed_steps(8, 4'b0000);
        wait_valid("tie", n);
        snap_id  = class_id;
        snap_cnt = class_count;
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            @(negedge clk);
            chk("hold_valid", int'(result_valid), 1);
            chk("hold_stable", int'({class_id, class_count}), int'({snap_id, snap_cnt}));
        end
        start = 1'b1;
        result_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        result_ready = 1'b0;
        chk("handshake_start_ignored", int'(busy), 0);
        @(negedge clk);
        chk("still_idle", int'(busy), 0);

        // Abort mid-window; the next window must not inherit the partial counts.
        do_start();
        feed_steps(7, 4'b1111);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        push("after_abort", 0, 16, 0, 0);
        do_start();
        feed_steps(16, 4'b0001);
        wait_valid("after_abort", n);
        handshake("after_abort");

        // Reset during the compare scan discards the window.
        do_start();
        feed_steps(16, 4'b0010);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        push("after_reset", 3, 16, 0, 0);
        do_start();
        feed_steps(16, 4'b1000);
        wait_valid("after_reset", n);
        handshake("after_reset");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
